dot_product_axil_bridge: RTL and testbench
==========================================

Name: dot_product_axil_bridge

Overview:
- Responder on the accelerator's simple memory request interface: services read_req/read_addr -> read_data/read_data_valid and write_req/write_addr/write_data -> write_done.
- Converts each request into a single AXI4-Lite master transaction toward system memory.
- Sits between the dot-product FSM and the AXI interconnect.
- One outstanding transaction at a time; sticky error reporting.

Parameters:
- ADDR_W, 32, width of request address and AXI araddr/awaddr.
- DATA_W, 32, width of request data and AXI rdata/wdata; wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- read_req  in  1  level request; held by initiator until read_data_valid.
- read_addr  in  ADDR_W  read address; valid while read_req high.
- read_data  out  DATA_W  returned data; valid when read_data_valid=1.
- read_data_valid  out  1  one-cycle pulse completing a read.
- write_req  in  1  level request; held until write_done.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- write_done  out  1  one-cycle pulse completing a write.
- err_status  out  2  sticky flags: bit0 read resp error, bit1 write resp error.
- err_clr  in  1  clears err_status.
- busy  out  1  high in any state other than IDLE.
- m_araddr/m_arvalid/m_arready  out/out/in  ADDR_W/1/1  AXI read address channel.
- m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  DATA_W/2/1/1  AXI read data channel.
- m_awaddr/m_awvalid/m_awready  out/out/in  ADDR_W/1/1  AXI write address channel.
- m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  DATA_W/DATA_W/8/1/1  AXI write data channel.
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI write response channel.
- m_arprot/m_awprot  out  3  constant 3'b000.

Behaviour:
- Reset values: every output 0, including all valid/ready outputs, read_data, err_status and busy; state=IDLE.
- Reset has priority and may be asserted mid-transaction: the FSM returns to IDLE and all AXI valids drop. Resets are system-wide, so interconnect state is cleared as well.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP.
- IDLE:
  - Samples requests every cycle. read_req has priority over write_req when both are high.
  - On read_req: capture read_addr into m_araddr, set m_arvalid=1, go to RD_ADDR.
  - On write_req: capture write_addr/write_data into m_awaddr/m_wdata, set m_wstrb all ones, m_awvalid=1, m_wvalid=1, go to WR_ADDR_DATA.
- RD_ADDR:
  - m_arvalid stays high until m_arready is sampled high; m_araddr is stable throughout.
  - On handshake: m_arvalid=0, m_rready=1, go to RD_DATA.
- RD_DATA:
  - On m_rvalid && m_rready: latch m_rdata into read_data, m_rready=0, read_data_valid=1 for the next cycle, go to RESP.
  - If m_rresp != 0, set err_status[0]. Data is still returned.
- WR_ADDR_DATA:
  - AW and W channels are tracked independently. m_awvalid drops on the cycle after its own handshake; m_wvalid likewise; either may complete first or both together.
  - Once both handshakes are done: m_bready=1, go to WR_RESP.
- WR_RESP:
  - On m_bvalid && m_bready: m_bready=0, write_done=1 for the next cycle, go to RESP.
  - If m_bresp != 0, set err_status[1].
- RESP:
  - read_data_valid or write_done is high for exactly this one cycle. Next state is IDLE.
  - No request is sampled in RESP. This gives the initiator one edge to drop or re-target its request; requests are sampled again on the following cycle.
- read_data holds its value until the next read completes.
- Zero-wait latency: request first seen high in cycle N -> read_data_valid/write_done in cycle N+3 -> next request accepted in cycle N+4.
- err_status:
  - err_clr clears both bits.
  - If err_clr and a new error occur in the same cycle, the set wins.
- A request dropped mid-transaction does not abort the AXI transaction; it completes and still pulses the completion output.

Test Plan:
- Zero-wait read, read_addr=0x100, slave returns rdata=0x0000_0007 with arready/rvalid immediate -> read_data_valid exactly 3 cycles after req, read_data=7, m_araddr=0x100.
- Back-pressured read: arready low 3 cycles, rvalid 2 cycles after AR handshake -> m_arvalid held 4 cycles with stable address; read_data_valid single pulse; busy high throughout.
- Write addr=0x200, data=0xFFFF_FFFE, wready asserted 2 cycles before awready -> m_wvalid drops first, m_awvalid persists; m_bready only after both handshakes; write_done one pulse; m_wstrb=4'hF.
- Initiator pattern: read_req held high across two reads, address switched 0x0->0x400 on the valid edge -> two AR transactions, addresses 0x0 then 0x400, no duplicate read.
- read_req and write_req high together -> read serviced first, then write; rresp=2'b10 -> err_status=2'b01 until err_clr pulse -> 2'b00.
- resetn low during RD_DATA -> next cycle all valids/readys and read_data_valid are 0, state IDLE; a fresh read afterwards completes normally.

Source files
------------

// File: rtl/dot_product_axil_bridge.sv
// rtl/dot_product_axil_bridge.sv - memory request responder issuing one AXI4-Lite transaction per request
// One transaction outstanding; read beats write on simultaneous requests; error flags are sticky until err_clr.
module dot_product_axil_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                read_req,
  input  logic [ADDR_W-1:0]   read_addr,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_data_valid,
  input  logic                write_req,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [DATA_W-1:0]   write_data,
  output logic                write_done,
  output logic [1:0]          err_status,
  input  logic                err_clr,
  output logic                busy,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [2:0]          m_arprot,
  output logic [2:0]          m_awprot
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESP
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   araddr_q, awaddr_q;
  logic [DATA_W-1:0]   wdata_q, read_data_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic                aw_done_q, w_done_q;
  logic                read_data_valid_q, write_done_q;
  logic [1:0]          err_q, err_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = arvalid_q && m_arready;
  assign r_hs  = rready_q && m_rvalid;
  assign aw_hs = awvalid_q && m_awready;
  assign w_hs  = wvalid_q && m_wready;
  assign b_hs  = bready_q && m_bvalid;

  // A new error in the same cycle as err_clr must survive the clear.
  always_comb begin
    err_d = err_clr ? 2'b00 : err_q;
    if (state_q == RD_DATA && r_hs && m_rresp != 2'b00) err_d[0] = 1'b1;
    if (state_q == WR_RESP && b_hs && m_bresp != 2'b00) err_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q           <= IDLE;
      araddr_q          <= '0;
      awaddr_q          <= '0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      read_data_q       <= '0;
      arvalid_q         <= 1'b0;
      rready_q          <= 1'b0;
      awvalid_q         <= 1'b0;
      wvalid_q          <= 1'b0;
      bready_q          <= 1'b0;
      aw_done_q         <= 1'b0;
      w_done_q          <= 1'b0;
      read_data_valid_q <= 1'b0;
      write_done_q      <= 1'b0;
      err_q             <= 2'b00;
    end else begin
      err_q             <= err_d;
      read_data_valid_q <= 1'b0;
      write_done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (read_req) begin
            araddr_q  <= read_addr;
            arvalid_q <= 1'b1;
            state_q   <= RD_ADDR;
          end else if (write_req) begin
            awaddr_q  <= write_addr;
            wdata_q   <= write_data;
            wstrb_q   <= {STRB_W{1'b1}};
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= WR_ADDR_DATA;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            read_data_q       <= m_rdata;
            rready_q          <= 1'b0;
            read_data_valid_q <= 1'b1;
            state_q           <= RESP;
          end
        end
        WR_ADDR_DATA: begin
          // AW and W complete independently, in either order or together.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bready_q     <= 1'b0;
            write_done_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_data       = read_data_q;
  assign read_data_valid = read_data_valid_q;
  assign write_done      = write_done_q;
  assign err_status      = err_q;
  assign busy            = (state_q != IDLE);
  assign m_araddr        = araddr_q;
  assign m_arvalid       = arvalid_q;
  assign m_rready        = rready_q;
  assign m_awaddr        = awaddr_q;
  assign m_awvalid       = awvalid_q;
  assign m_wdata         = wdata_q;
  assign m_wstrb         = wstrb_q;
  assign m_wvalid        = wvalid_q;
  assign m_bready        = bready_q;
  assign m_arprot        = 3'b000;
  assign m_awprot        = 3'b000;

endmodule

// File: tb/tb_dot_product_axil_bridge.sv
// tb/tb_dot_product_axil_bridge.sv - self-checking bench for dot_product_axil_bridge
// Directed initiator sequence against a delay-configurable AXI4-Lite slave with scoreboard queues.
module tb_dot_product_axil_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        read_req, write_req, err_clr;
  logic [31:0] read_addr, write_addr, write_data, read_data;
  logic        read_data_valid, write_done, busy;
  logic [1:0]  err_status;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_arprot, m_awprot;

  always #5 clk = ~clk;

  dot_product_axil_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .read_req(read_req), .read_addr(read_addr), .read_data(read_data),
    .read_data_valid(read_data_valid),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
    .write_done(write_done), .err_status(err_status), .err_clr(err_clr), .busy(busy),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arprot(m_arprot), .m_awprot(m_awprot)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_ar[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_awaddr[$];
  logic [31:0] exp_wdata[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave configuration and bookkeeping
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, ar_count = 0;
  bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_seen, w_seen;

  initial begin
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
        continue;
      end
      // Retire handshakes that completed on the previous rising edge
      if (r_hs) begin r_hs = 0; r_pend = 0; m_rvalid = 0; end
      if (ar_hs) begin ar_hs = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; end
      if (aw_hs) begin aw_hs = 0; aw_cnt = 0; aw_seen = 1; end
      if (w_hs) begin w_hs = 0; w_cnt = 0; w_seen = 1; end
      if (b_hs) begin b_hs = 0; b_pend = 0; m_bvalid = 0; end
      if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_pend = 1; b_cnt = 0; end

      m_arready = 0;
      if (m_arvalid) begin
        if (ar_cnt >= ar_dly) begin
          m_arready = 1; ar_hs = 1; ar_count++;
          check("ar_expected", 32'(exp_ar.size() != 0), 32'd1);
          if (exp_ar.size() != 0) check("ar_addr", m_araddr, exp_ar.pop_front());
        end else ar_cnt++;
      end
      if (r_pend && !m_rvalid) begin
        if (r_cnt >= r_dly) begin m_rvalid = 1; m_rdata = s_rdata; m_rresp = s_rresp; end
        else r_cnt++;
      end
      if (m_rvalid && m_rready) r_hs = 1;

      m_awready = 0;
      if (m_awvalid) begin
        if (aw_cnt >= aw_dly) begin
          m_awready = 1; aw_hs = 1;
          check("aw_expected", 32'(exp_awaddr.size() != 0), 32'd1);
          if (exp_awaddr.size() != 0) check("aw_addr", m_awaddr, exp_awaddr.pop_front());
        end else aw_cnt++;
      end
      m_wready = 0;
      if (m_wvalid) begin
        if (w_cnt >= w_dly) begin
          m_wready = 1; w_hs = 1;
          check("wstrb", 32'(m_wstrb), 32'hF);
          check("w_expected", 32'(exp_wdata.size() != 0), 32'd1);
          if (exp_wdata.size() != 0) check("w_data", m_wdata, exp_wdata.pop_front());
        end else w_cnt++;
      end
      if (b_pend && !m_bvalid) begin
        if (b_cnt >= b_dly) begin m_bvalid = 1; m_bresp = s_bresp; end
        else b_cnt++;
      end
      if (m_bvalid && m_bready) b_hs = 1;
    end
  end

  // Read-data scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && read_data_valid) begin
        check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) check("read_data", read_data, exp_rd.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    read_req = 1; read_addr = a; s_rdata = d; s_rresp = resp;
    exp_ar.push_back(a); exp_rd.push_back(d);
  endtask

  task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    write_req = 1; write_addr = a; write_data = d; s_bresp = resp;
    exp_awaddr.push_back(a); exp_wdata.push_back(d);
  endtask

  task automatic wait_rdv(input string tag, output int n);
    n = 0;
    do begin tick(); n++; end while (!read_data_valid && n < 60);
    check({tag, "_rdv_seen"}, 32'(read_data_valid), 32'd1);
  endtask

  task automatic wait_wd(input string tag, output int n);
    n = 0;
    do begin tick(); n++; end while (!write_done && n < 60);
    check({tag, "_wd_seen"}, 32'(write_done), 32'd1);
  endtask

  initial begin
    int n, arv_cycles, extra, ar_before, rd_at, wd_at;
    bit addr_ok, busy_ok, wfirst, early_b;

    resetn = 0; read_req = 0; write_req = 0; err_clr = 0;
    read_addr = '0; write_addr = '0; write_data = '0;
    repeat (3) tick();
    check("reset_ctrl", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                             read_data_valid, write_done, busy}), 32'd0);
    check("reset_err_prot", 32'({err_status, m_arprot, m_awprot}), 32'd0);
    check("reset_read_data", read_data, 32'd0);
    check("reset_axi_payload", m_araddr | m_awaddr | m_wdata | 32'(m_wstrb), 32'd0);
    resetn = 1;
    tick();

    // Zero-wait read
    start_read(32'h100, 32'h7, 2'b00);
    wait_rdv("t1", n);
    check("t1_latency", 32'(n), 32'd3);
    check("t1_araddr", m_araddr, 32'h100);
    read_req = 0;
    tick();
    check("t1_single_pulse", 32'({read_data_valid, busy}), 32'd0);

    // Back-pressured read
    ar_dly = 3; r_dly = 2;
    start_read(32'h180, 32'hCAFE_0001, 2'b00);
    n = 0; arv_cycles = 0; addr_ok = 1; busy_ok = 1;
    do begin
      tick(); n++;
      if (m_arvalid) begin
        arv_cycles++;
        if (m_araddr !== 32'h180) addr_ok = 0;
      end
      if (!busy) busy_ok = 0;
    end while (!read_data_valid && n < 60);
    read_req = 0;
    check("t2_rdv_seen", 32'(read_data_valid), 32'd1);
    check("t2_arvalid_cycles", 32'(arv_cycles), 32'd4);
    check("t2_araddr_stable", 32'(addr_ok), 32'd1);
    check("t2_busy_throughout", 32'(busy_ok), 32'd1);
    extra = 0;
    repeat (4) begin tick(); if (read_data_valid) extra++; end
    check("t2_extra_rdv", 32'(extra), 32'd0);
    ar_dly = 0; r_dly = 0;

    // Write with W completing before AW
    aw_dly = 2;
    start_write(32'h200, 32'hFFFF_FFFE, 2'b00);
    n = 0; wfirst = 0; early_b = 0;
    do begin
      tick(); n++;
      if (!m_wvalid && m_awvalid) wfirst = 1;
      if (m_bready && (m_awvalid || m_wvalid)) early_b = 1;
    end while (!write_done && n < 60);
    write_req = 0;
    check("t3_wd_seen", 32'(write_done), 32'd1);
    check("t3_latency", 32'(n), 32'd5);
    check("t3_w_drops_first", 32'(wfirst), 32'd1);
    check("t3_no_early_bready", 32'(early_b), 32'd0);
    extra = 0;
    repeat (3) begin tick(); if (write_done) extra++; end
    check("t3_extra_wd", 32'(extra), 32'd0);
    aw_dly = 0;

    // Initiator holds read_req and re-targets on the valid edge
    ar_before = ar_count;
    start_read(32'h0, 32'h11, 2'b00);
    wait_rdv("t4a", n);
    check("t4_first_latency", 32'(n), 32'd3);
    start_read(32'h400, 32'h22, 2'b00);
    wait_rdv("t4b", n);
    check("t4_second_latency", 32'(n), 32'd4);
    read_req = 0;
    repeat (4) tick();
    check("t4_ar_count", 32'(ar_count - ar_before), 32'd2);

    // Simultaneous requests: read first, read error is sticky
    start_read(32'h300, 32'h33, 2'b10);
    start_write(32'h304, 32'h44, 2'b00);
    n = 0; rd_at = 0; wd_at = 0;
    while ((rd_at == 0 || wd_at == 0) && n < 60) begin
      tick(); n++;
      if (read_data_valid) begin
        rd_at = n; read_req = 0;
        check("t5_err_after_read", 32'(err_status), 32'd1);
      end
      if (write_done) begin wd_at = n; write_req = 0; end
    end
    check("t5_read_at", 32'(rd_at), 32'd3);
    check("t5_write_at", 32'(wd_at), 32'd7);
    repeat (2) tick();
    check("t5_err_sticky", 32'(err_status), 32'd1);
    err_clr = 1; tick(); err_clr = 0;
    check("t5_err_cleared", 32'(err_status), 32'd0);

    // Write response error
    start_write(32'h308, 32'h5, 2'b11);
    wait_wd("t5b", n);
    write_req = 0;
    check("t5b_err_write", 32'(err_status), 32'd2);
    s_bresp = 2'b00;
    err_clr = 1; tick(); err_clr = 0;
    check("t5b_err_cleared", 32'(err_status), 32'd0);

    // Reset in RD_DATA, then a fresh read
    r_dly = 3;
    start_read(32'h500, 32'h55, 2'b00);
    n = 0;
    do begin tick(); n++; end while (!m_rready && n < 60);
    check("t6_in_rd_data", 32'(m_rready), 32'd1);
    resetn = 0; read_req = 0;
    tick();
    check("t6_ctrl_after_reset", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                                      read_data_valid, write_done, busy}), 32'd0);
    check("t6_read_data_reset", read_data, 32'd0);
    exp_rd.delete();
    tick();
    resetn = 1; r_dly = 0;
    tick();
    start_read(32'h600, 32'h66, 2'b00);
    wait_rdv("t6", n);
    check("t6_fresh_latency", 32'(n), 32'd3);
    read_req = 0;
    repeat (3) tick();

    check("sb_ar_empty", 32'(exp_ar.size()), 32'd0);
    check("sb_rd_empty", 32'(exp_rd.size()), 32'd0);
    check("sb_aw_empty", 32'(exp_awaddr.size() + exp_wdata.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
